// File: rtl/odd_counter_pkg.sv
// Shared constants and helpers for odd-only counters.
package odd_counter_pkg;

  // Value every odd counter returns to on reset or clear.
  localparam int ODD_RESET_VAL = 1;

  // Distance between consecutive odd values.
  localparam int ODD_STEP = 2;

  // Largest odd value that fits in w bits (all ones), for w in 1..32.
  function automatic logic [31:0] odd_max(input int unsigned w);
    if (w >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/odd_step.sv
// Next odd value: step up or down by two. Modulo wrap comes free from the
// fixed-width add/subtract, and odd inputs always give odd outputs.
module odd_step
  import odd_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             up,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(ODD_STEP);

  // Add or subtract the step; overflow/underflow wraps 2^W-1 <-> 1.
  always_comb begin
    nxt = cur;
    if (up) begin
      nxt = cur + STEP;
    end else begin
      nxt = cur - STEP;
    end
  end

endmodule

// File: rtl/odd_counter.sv
// Up/down counter that only ever holds odd values, with clear, load and a
// terminal-count flag announcing the wrap on the next enabled edge.
module odd_counter
  import odd_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(ODD_RESET_VAL);
  localparam logic [WIDTH-1:0] MAX_ODD   = WIDTH'(odd_max(WIDTH));

  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] count_nxt;

  odd_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cur (count),
    .up  (up),
    .nxt (step_val)
  );

  // Priority select: clear, then load (bit 0 forced high), then step, else hold.
  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = RESET_VAL;
    end else if (load) begin
      count_nxt = load_val | RESET_VAL;
    end else if (en) begin
      count_nxt = step_val;
    end
  end

  // Count register; reset drops straight to 1 without waiting for the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_VAL;
    end else begin
      count <= count_nxt;
    end
  end

  // Terminal count: the next enabled step wraps; held low while in reset.
  always_comb begin
    tc = 1'b0;
    if (rst_n && en && !clear && !load) begin
      tc = up ? (count == MAX_ODD) : (count == RESET_VAL);
    end
  end

endmodule

// File: tb/tb_odd_counter.sv
// Testbench for odd_counter: arithmetic reference model plus directed scenarios.
module tb_odd_counter;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic         up = 1'b1;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         tc;

  int vectors = 0;
  int miscompares = 0;

  odd_counter #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  // Reference model: the count as a plain integer, updated by the stated rules.
  int m = 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= 1;
    end else if (clear) begin
      m <= 1;
    end else if (load) begin
      m <= (int'(load_val) / 2) * 2 + 1;
    end else if (en) begin
      m <= up ? (m + 2) % MOD : (m - 2 + MOD) % MOD;
    end
  end

  // Expected flag: high when an enabled step would wrap on the next edge.
  function automatic int model_tc();
    int nxt;
    if (!rst_n || !en || clear || load) return 0;
    nxt = up ? m + 2 : m - 2;
    return (nxt >= MOD || nxt < 0) ? 1 : 0;
  endfunction

  // Every-cycle check against the model, away from the rising edge.
  always @(negedge clk) begin
    vectors++;
    if (int'(count) != m || count[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL model_count t=%0t: got %0d want %0d", $time, count, m);
    end
    vectors++;
    if (int'(tc) != model_tc()) begin
      miscompares++;
      $display("FAIL model_tc t=%0t: got %0d want %0d", $time, tc, model_tc());
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset then count up from 1
    #12;
    chk("rst_count", int'(count), 1);
    up = 1'b0;
    #1;
    chk("rst_tc_low", int'(tc), 0);
    up = 1'b1;
    rst_n = 1'b1;
    step(); chk("up_edge1", int'(count), 3);
    step(); chk("up_edge2", int'(count), 5);
    step(); chk("up_edge3", int'(count), 7);

    // Up wrap
    load_val = 8'hFE; load = 1'b1;
    step(); chk("load_fe", int'(count), 255);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1; chk("tc_up_wrap", int'(tc), 1);
    step(); chk("up_wrap_cnt", int'(count), 1);
    chk("up_wrap_tc", int'(tc), 0);

    // Down wrap
    up = 1'b0;
    #1; chk("tc_dn_wrap", int'(tc), 1);
    step(); chk("dn_wrap_cnt", int'(count), 255);
    chk("dn_tc_clear", int'(tc), 0);
    step(); chk("dn_next", int'(count), 253);

    // Priority clear > load > count
    load_val = 8'h09; load = 1'b1;
    step(); chk("load_9", int'(count), 9);
    clear = 1'b1; load = 1'b1; load_val = 8'h40; en = 1'b1; up = 1'b1;
    #1; chk("tc_masked", int'(tc), 0);
    step(); chk("clear_wins", int'(count), 1);
    clear = 1'b0;
    step(); chk("load_40", int'(count), 8'h41);
    load_val = 8'h4C;
    step(); chk("load_bit0_ign", int'(count), 8'h4D);

    // Hold with en=0, then async reset mid-cycle at count=77
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up = i[0];
      step(); chk("hold", int'(count), 77);
    end
    #1; rst_n = 1'b0;
    #1; chk("async_rst", int'(count), 1);
    en = 1'b1; up = 1'b0;
    #1; chk("rst_tc_gate", int'(tc), 0);
    @(negedge clk); #1;
    rst_n = 1'b1; up = 1'b1;
    step(); chk("first_after_rst", int'(count), 3);
    step(); chk("second_after_rst", int'(count), 5);

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
